// File: rtl/dmem_arbiter_if.sv
// Two-port data-memory arbiter bus: requester ports A and B plus the shared memory side.
// slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata;
    logic        a_gnt;
    logic        a_done;
    logic [31:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic        b_done;
    logic [31:0] b_rdata;

    logic        mem_read_flag;
    logic        mem_write_flag;
    logic [4:0]  mem_addr;
    logic [31:0] mem_val;
    logic [31:0] mem_read_out;
    logic        busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_read_out,
        output a_gnt, a_done, a_rdata,
        output b_gnt, b_done, b_rdata,
        output mem_read_flag, mem_write_flag, mem_addr, mem_val,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_read_out,
        input  a_gnt, a_done, a_rdata,
        input  b_gnt, b_done, b_rdata,
        input  mem_read_flag, mem_write_flag, mem_addr, mem_val,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates core (A) and debug/DMA (B) accesses onto one single-ported data memory,
// one access per three cycles: IDLE picks and latches, ISSUE strobes memory, RESP completes.
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// ISSUE | drive latched command to memory, pulse winner's gnt
// RESP  | pulse winner's done, capture read data at the end of the cycle
module dmem_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        any_req;
    logic        sel_b;
    logic        cmd_b;
    logic        cmd_we;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        last_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    assign any_req = bus.a_req | bus.b_req;

    // B wins only if A is absent, or under round-robin when A had the last grant.
    always_comb begin
        if (FIXED_PRIO != 0) begin
            sel_b = !bus.a_req;
        end else begin
            sel_b = bus.b_req && (!bus.a_req || !last_b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = any_req ? ISSUE : IDLE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.a_gnt          = 1'b0;
        bus.b_gnt          = 1'b0;
        bus.a_done         = 1'b0;
        bus.b_done         = 1'b0;
        bus.mem_read_flag  = 1'b0;
        bus.mem_write_flag = 1'b0;
        unique case (state)
            ISSUE: begin
                bus.a_gnt          = !cmd_b;
                bus.b_gnt          = cmd_b;
                bus.mem_write_flag = cmd_we;
                bus.mem_read_flag  = !cmd_we;
            end
            RESP: begin
                bus.a_done = !cmd_b;
                bus.b_done = cmd_b;
            end
            default: ;
        endcase
    end

    // Reset with last_b set so A wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_b     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            last_b    <= 1'b1;
        end else if (state == IDLE && any_req) begin
            cmd_b     <= sel_b;
            cmd_we    <= sel_b ? bus.b_we    : bus.a_we;
            cmd_addr  <= sel_b ? bus.b_addr  : bus.a_addr;
            cmd_wdata <= sel_b ? bus.b_wdata : bus.a_wdata;
            last_b    <= sel_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (state == RESP && !cmd_we) begin
            if (cmd_b) begin
                rdata_b <= bus.mem_read_out;
            end else begin
                rdata_a <= bus.mem_read_out;
            end
        end
    end

    // The latched command only changes on entry to ISSUE, so it holds between accesses.
    assign bus.mem_addr = cmd_addr;
    assign bus.mem_val  = cmd_wdata;
    assign bus.a_rdata  = rdata_a;
    assign bus.b_rdata  = rdata_b;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// cycle-count transaction model, and a fixed-priority instance checked directly.
module tb_dmem_arbiter;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if m0();
    dmem_arbiter_if m1();

    dmem_arbiter #(.FIXED_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(m0));
    dmem_arbiter #(.FIXED_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(m1));

    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem0[i] <= '0;
            m0.mem_read_out <= '0;
        end else begin
            if (m0.mem_write_flag) mem0[m0.mem_addr] <= m0.mem_val;
            if (m0.mem_read_flag) m0.mem_read_out <= mem0[m0.mem_addr];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem1[i] <= '0;
            m1.mem_read_out <= '0;
        end else begin
            if (m1.mem_write_flag) mem1[m1.mem_addr] <= m1.mem_val;
            if (m1.mem_read_flag) m1.mem_read_out <= mem1[m1.mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cnt, rd_cnt;

    // transaction model: one access occupies cycles start (gnt) and start+1 (done)
    int          idle_from;
    bit          acc_valid;
    bit          acc_b;
    logic        acc_we;
    logic [4:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] acc_rval;
    int          acc_start;
    bit          last_b;
    logic [31:0] ref_mem [32];
    logic [31:0] e_rdata_a, e_rdata_b;
    logic        e_gnt_a, e_gnt_b, e_done_a, e_done_b, e_busy, e_rd, e_wr;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        acc_valid = 1'b0;
        last_b    = 1'b1;
        idle_from = cyc;
        e_rdata_a = '0;
        e_rdata_b = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    endtask

    task automatic model_sample();
        bit pb;
        if (cyc >= idle_from && (m0.a_req || m0.b_req)) begin
            pb        = m0.b_req && (!m0.a_req || !last_b);
            acc_valid = 1'b1;
            acc_b     = pb;
            acc_we    = pb ? m0.b_we : m0.a_we;
            acc_addr  = pb ? m0.b_addr : m0.a_addr;
            acc_wdata = pb ? m0.b_wdata : m0.a_wdata;
            acc_start = cyc + 1;
            idle_from = cyc + 3;
            last_b    = pb;
            if (acc_we) ref_mem[acc_addr] = acc_wdata;
            else acc_rval = ref_mem[acc_addr];
        end
    endtask

    task automatic model_expect();
        e_gnt_a = 0; e_gnt_b = 0; e_done_a = 0; e_done_b = 0;
        e_busy = 0; e_rd = 0; e_wr = 0;
        if (acc_valid) begin
            if (cyc == acc_start) begin
                e_gnt_a = !acc_b;
                e_gnt_b = acc_b;
                e_busy  = 1;
                e_wr    = acc_we;
                e_rd    = !acc_we;
            end else if (cyc == acc_start + 1) begin
                e_done_a = !acc_b;
                e_done_b = acc_b;
                e_busy   = 1;
            end else if (cyc == acc_start + 2 && !acc_we) begin
                if (acc_b) e_rdata_b = acc_rval;
                else e_rdata_a = acc_rval;
            end
        end
    endtask

    task automatic compare();
        chk1("a_gnt", m0.a_gnt, e_gnt_a);
        chk1("b_gnt", m0.b_gnt, e_gnt_b);
        chk1("a_done", m0.a_done, e_done_a);
        chk1("b_done", m0.b_done, e_done_b);
        chk1("busy", m0.busy, e_busy);
        chk1("mem_read_flag", m0.mem_read_flag, e_rd);
        chk1("mem_write_flag", m0.mem_write_flag, e_wr);
        chk32("a_rdata", m0.a_rdata, e_rdata_a);
        chk32("b_rdata", m0.b_rdata, e_rdata_b);
        if (e_rd || e_wr) chk32("mem_addr", {27'd0, m0.mem_addr}, {27'd0, acc_addr});
        if (e_wr) chk32("mem_val", m0.mem_val, acc_wdata);
        if (m0.mem_write_flag) wr_cnt++;
        if (m0.mem_read_flag) rd_cnt++;
    endtask

    task automatic tick();
        model_sample();
        @(posedge clk);
        #1;
        cyc++;
        model_expect();
        compare();
    endtask

    task automatic reset_checks(input string tag);
        chk1({tag, "_busy"}, m0.busy, 1'b0);
        chk1({tag, "_a_gnt"}, m0.a_gnt, 1'b0);
        chk1({tag, "_b_gnt"}, m0.b_gnt, 1'b0);
        chk1({tag, "_a_done"}, m0.a_done, 1'b0);
        chk1({tag, "_b_done"}, m0.b_done, 1'b0);
        chk1({tag, "_rd_flag"}, m0.mem_read_flag, 1'b0);
        chk1({tag, "_wr_flag"}, m0.mem_write_flag, 1'b0);
        chk32({tag, "_mem_addr"}, {27'd0, m0.mem_addr}, 32'd0);
        chk32({tag, "_mem_val"}, m0.mem_val, 32'd0);
        chk32({tag, "_a_rdata"}, m0.a_rdata, 32'd0);
        chk32({tag, "_b_rdata"}, m0.b_rdata, 32'd0);
    endtask

    task automatic wait_gnt(input bit port);
        bit got = 0;
        for (int n = 0; n < 12 && !got; n++) begin
            tick();
            got = port ? e_gnt_b : e_gnt_a;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wait_gnt: no grant for port %0d within 12 cycles", port);
        end
    endtask

    task automatic do_access(input bit port, input logic we, input logic [4:0] addr,
                             input logic [31:0] data);
        if (port) {m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata} = {1'b1, we, addr, data};
        else {m0.a_req, m0.a_we, m0.a_addr, m0.a_wdata} = {1'b1, we, addr, data};
        wait_gnt(port);
        tick();
        if (port) m0.b_req = 1'b0;
        else m0.a_req = 1'b0;
        tick();
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.req   = 1'b1;
        c.we    = 1'($urandom_range(1, 0));
        c.addr  = 5'($urandom_range(7, 0));
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic cmd_t next_cmd(input cmd_t cur, input bit granted_prev);
        cmd_t n = cur;
        if (granted_prev) begin
            if ($urandom_range(1, 0) == 0) n.req = 1'b0;
            else n = rand_cmd();
        end else if (!cur.req && $urandom_range(2, 0) == 0) begin
            n = rand_cmd();
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk1("rw_excl0", m0.mem_read_flag & m0.mem_write_flag, 1'b0);
            chk1("gnt_excl0", m0.a_gnt & m0.b_gnt, 1'b0);
            chk1("rw_excl1", m1.mem_read_flag & m1.mem_write_flag, 1'b0);
            chk1("gnt_excl1", m1.a_gnt & m1.b_gnt, 1'b0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gnt_q[$];
        int done_q[$];
        bit ga, gb;

        {m0.a_req, m0.a_we, m0.a_addr, m0.a_wdata} = '0;
        {m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata} = '0;
        {m1.a_req, m1.a_we, m1.a_addr, m1.a_wdata} = '0;
        {m1.b_req, m1.b_we, m1.b_addr, m1.b_wdata} = '0;
        wr_cnt = 0;
        rd_cnt = 0;

        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
        cyc = 0;
        model_reset();

        // A write then read of addr 3
        wr_cnt = 0;
        rd_cnt = 0;
        {m0.a_req, m0.a_we, m0.a_addr, m0.a_wdata} = {1'b1, 1'b1, 5'd3, 32'hDEADBEEF};
        tick();
        chk1("p1_wr_gnt", m0.a_gnt, 1'b1);
        chk1("p1_wr_flag", m0.mem_write_flag, 1'b1);
        tick();
        chk1("p1_wr_done", m0.a_done, 1'b1);
        {m0.a_req, m0.a_we, m0.a_addr, m0.a_wdata} = {1'b1, 1'b0, 5'd3, 32'd0};
        tick();
        chk1("p1_idle", m0.busy, 1'b0);
        tick();
        chk1("p1_rd_gnt", m0.a_gnt, 1'b1);
        tick();
        chk1("p1_rd_done", m0.a_done, 1'b1);
        m0.a_req = 1'b0;
        tick();
        chk32("p1_rdata", m0.a_rdata, 32'hDEADBEEF);
        chk32("p1_wr_pulses", wr_cnt, 32'd1);
        chk32("p1_rd_pulses", rd_cnt, 32'd1);

        // both ports reading continuously: alternate grants
        do_access(1'b0, 1'b1, 5'd1, 32'hA1A10001);
        do_access(1'b1, 1'b1, 5'd2, 32'hB2B20002);
        {m0.a_req, m0.a_we, m0.a_addr, m0.a_wdata} = {1'b1, 1'b0, 5'd1, 32'd0};
        {m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata} = {1'b1, 1'b0, 5'd2, 32'd0};
        for (int i = 0; i < 11; i++) begin
            tick();
            if (m0.a_gnt) gnt_q.push_back(0);
            if (m0.b_gnt) gnt_q.push_back(1);
            if (m0.a_done || m0.b_done) done_q.push_back(cyc);
        end
        m0.a_req = 1'b0;
        m0.b_req = 1'b0;
        repeat (3) tick();
        chk32("p2_gnt_count", gnt_q.size(), 32'd4);
        chk32("p2_done_count", done_q.size(), 32'd4);
        if (gnt_q.size() >= 4) begin
            chk32("p2_order0", gnt_q[0], 32'd0);
            chk32("p2_order1", gnt_q[1], 32'd1);
            chk32("p2_order2", gnt_q[2], 32'd0);
            chk32("p2_order3", gnt_q[3], 32'd1);
        end
        for (int i = 1; i < done_q.size(); i++) chk32("p2_done_gap", done_q[i] - done_q[i-1], 32'd3);
        chk32("p2_a_rdata", m0.a_rdata, 32'hA1A10001);
        chk32("p2_b_rdata", m0.b_rdata, 32'hB2B20002);

        // single B read, A idle
        {m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata} = {1'b1, 1'b0, 5'd5, 32'd0};
        tick();
        chk1("p3_b_gnt", m0.b_gnt, 1'b1);
        chk1("p3_busy1", m0.busy, 1'b1);
        chk1("p3_a_gnt", m0.a_gnt, 1'b0);
        tick();
        chk1("p3_b_done", m0.b_done, 1'b1);
        chk1("p3_busy2", m0.busy, 1'b1);
        chk1("p3_a_done", m0.a_done, 1'b0);
        m0.b_req = 1'b0;
        tick();
        chk1("p3_busy3", m0.busy, 1'b0);
        chk32("p3_a_rdata", m0.a_rdata, 32'hA1A10001);

        // reset during ISSUE of a B write aborts it
        {m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata} = {1'b1, 1'b1, 5'd7, 32'h12345678};
        wait_gnt(1'b1);
        rst = 1'b1;
        #1;
        reset_checks("abort");
        {m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata} = '0;
        rst = 1'b0;
        model_reset();
        tick();
        chk1("p4_no_done", m0.b_done, 1'b0);
        do_access(1'b1, 1'b0, 5'd7, 32'd0);
        chk32("p4_rdata", m0.b_rdata, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            ga = acc_valid && !acc_b && cyc == acc_start + 1;
            gb = acc_valid && acc_b && cyc == acc_start + 1;
            {m0.a_req, m0.a_we, m0.a_addr, m0.a_wdata} =
                next_cmd({m0.a_req, m0.a_we, m0.a_addr, m0.a_wdata}, ga);
            {m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata} =
                next_cmd({m0.b_req, m0.b_we, m0.b_addr, m0.b_wdata}, gb);
            tick();
        end
        m0.a_req = 1'b0;
        m0.b_req = 1'b0;
        repeat (4) tick();

        // fixed priority: B starves until A drops
        {m1.a_req, m1.a_we, m1.a_addr, m1.a_wdata} = {1'b1, 1'b0, 5'd1, 32'd0};
        {m1.b_req, m1.b_we, m1.b_addr, m1.b_wdata} = {1'b1, 1'b0, 5'd2, 32'd0};
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            chk1("fp_a_gnt", m1.a_gnt, (k % 3 == 1) && k <= 10);
            chk1("fp_a_done", m1.a_done, (k % 3 == 2) && k <= 11);
            chk1("fp_b_gnt", m1.b_gnt, k == 13);
            chk1("fp_b_done", m1.b_done, k == 14);
            if (k == 11) m1.a_req = 1'b0;
            if (k == 14) m1.b_req = 1'b0;
        end
        @(posedge clk);
        #1;
        chk32("fp_b_rdata", m1.b_rdata, 32'd0);
        chk1("fp_idle", m1.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
